// File: rtl/console_uart_pkg.sv
// console_uart_pkg: shared FSM state type, register offsets and status bit positions
package console_uart_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  localparam logic [31:0] DATA_OFS = 32'd0;
  localparam logic [31:0] STATUS_OFS = 32'd4;
  localparam int ST_BUSY = 0;
  localparam int ST_FULL = 1;
  localparam int ST_OVF = 2;
  localparam int ST_LVL = 4;
endpackage

// File: rtl/console_uart_fifo.sv
// console_uart_fifo: byte FIFO with wrap-around pointers one bit wider than the index
module console_uart_fifo #(
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int LW = AW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic [7:0]    din,
  output logic [7:0]    dout,
  output logic          full,
  output logic          empty,
  output logic [LW-1:0] level
);
  logic [7:0] mem [DEPTH];
  logic [LW-1:0] wptr, rptr;
  logic do_push, do_pop;
  assign level = wptr - rptr;
  assign full = level == LW'(DEPTH);
  assign empty = wptr == rptr;
  assign do_push = push & ~full;
  assign do_pop = pop & ~empty;
  assign dout = mem[rptr[AW-1:0]];
  // pointer update; a push into a full FIFO is dropped even if a pop happens on the same edge
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop) rptr <= rptr + 1'b1;
    end
  // storage needs no reset; the pointers define what is valid
  always_ff @(posedge clk)
    if (do_push) mem[wptr[AW-1:0]] <= din;
endmodule

// File: rtl/console_uart.sv
// console_uart: memory-mapped transmit-only console UART; CONSOLE_UART_PARITY_EN adds an even parity bit
module console_uart
  import console_uart_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h1000_0000,
  parameter int CLK_DIV = 868,
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] mem_addr,
  input  logic [3:0]  mem_write,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_rdata,
  output logic        tx
);
  localparam int LW = $clog2(FIFO_DEPTH) + 1;
  localparam int CW = $clog2(CLK_DIV);
  state_t state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [2:0] bit_idx, bit_nxt;
  logic [7:0] shreg, sh_nxt, dout;
  logic [LW-1:0] level;
  logic [3:0] lvl4;
  logic [31:0] status;
  logic tx_nxt, pop, full, empty, overflow, busy, tick, wr_data, wr_stat;
  logic unused;
  assign unused = ^{mem_wdata[31:8], mem_write[3:1]};
  assign wr_data = mem_addr == BASE_ADDR + DATA_OFS && mem_write[0];
  assign wr_stat = mem_addr == BASE_ADDR + STATUS_OFS && mem_write[0] && mem_wdata[2];
  assign tick = cnt == CW'(CLK_DIV - 1);
  assign busy = state != IDLE || !empty;
  assign lvl4 = 32'(level) > 32'd15 ? 4'hf : 4'(level);

  console_uart_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (wr_data),
    .pop   (pop),
    .din   (mem_wdata[7:0]),
    .dout  (dout),
    .full  (full),
    .empty (empty),
    .level (level)
  );

  // status word assembled from the live FIFO and transmitter state
  always_comb begin
    status = '0;
    status[ST_BUSY] = busy;
    status[ST_FULL] = full;
    status[ST_OVF] = overflow;
    status[ST_LVL +: 4] = lvl4;
  end

  // frame sequencing: each non-idle state holds for CLK_DIV cycles; a new byte is fetched from IDLE or at the end of STOP
  always_comb begin
    state_nxt = state;
    cnt_nxt = (state == IDLE || tick) ? '0 : cnt + 1'b1;
    bit_nxt = bit_idx;
    sh_nxt = shreg;
    pop = 1'b0;
    case (state)
      IDLE:
        if (!empty) begin
          pop = 1'b1;
          sh_nxt = dout;
          state_nxt = START;
        end
      START:
        if (tick) begin
          state_nxt = DATA;
          bit_nxt = '0;
        end
      DATA:
        if (tick) begin
          bit_nxt = bit_idx + 1'b1;
`ifdef CONSOLE_UART_PARITY_EN
          if (bit_idx == 3'd7) state_nxt = PARITY;
`else
          if (bit_idx == 3'd7) state_nxt = STOP;
`endif
        end
      PARITY:
        if (tick) state_nxt = STOP;
      STOP:
        if (tick) begin
          if (!empty) begin
            pop = 1'b1;
            sh_nxt = dout;
            state_nxt = START;
          end else state_nxt = IDLE;
        end
      default: state_nxt = IDLE;
    endcase
    tx_nxt = state_nxt == START ? 1'b0 :
             state_nxt == DATA ? sh_nxt[bit_nxt] :
             state_nxt == PARITY ? ^sh_nxt : 1'b1;
  end

  // transmitter registers; tx is registered so the line never glitches and reset forces it high at once
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      cnt <= '0;
      bit_idx <= '0;
      shreg <= '0;
      tx <= 1'b1;
    end else begin
      state <= state_nxt;
      cnt <= cnt_nxt;
      bit_idx <= bit_nxt;
      shreg <= sh_nxt;
      tx <= tx_nxt;
    end

  // sticky overflow; a fresh overflow takes priority over the software clear
  always_ff @(posedge clk or negedge reset)
    if (!reset) overflow <= 1'b0;
    else if (wr_data && full) overflow <= 1'b1;
    else if (wr_stat) overflow <= 1'b0;

  // registered read port with no side effects
  always_ff @(posedge clk or negedge reset)
    if (!reset) mem_rdata <= '0;
    else mem_rdata <= mem_addr == BASE_ADDR + STATUS_OFS ? status : '0;
endmodule

// File: tb/tb_console_uart.sv
// tb_console_uart: queue-based line model checked every cycle plus directed literal checks
module tb_console_uart;
  localparam logic [31:0] BASE = 32'h1000_0000;
  localparam int CLK_DIV = 4;
  localparam int DEPTH = 8;
`ifdef CONSOLE_UART_PARITY_EN
  localparam int FB = 11;
`else
  localparam int FB = 10;
`endif
  logic clk, reset, tx;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0] mem_write;
  int checks, failures;
  bit run;
  logic [7:0] q[$];
  bit line[$];
  bit m_ovf, in_frame;
  logic exp_tx;
  logic [31:0] exp_rdata;
  logic [9:0] lit55;

  console_uart #(.BASE_ADDR(BASE), .CLK_DIV(CLK_DIV), .FIFO_DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .mem_addr  (mem_addr),
    .mem_write (mem_write),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .tx        (tx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h time=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [10:0] frame_of(input logic [7:0] b);
`ifdef CONSOLE_UART_PARITY_EN
    return {1'b1, ^b, b, 1'b0};
`else
    return {2'b11, b, 1'b0};
`endif
  endfunction

  // line model: bytes wait in a bounded queue; when the line is free a whole frame is expanded into per-cycle samples
  always @(posedge clk or negedge reset)
    if (!reset) begin
      q.delete();
      line.delete();
      m_ovf = 1'b0;
      in_frame = 1'b0;
      exp_tx = 1'b1;
      exp_rdata = '0;
    end else begin
      logic [10:0] f;
      bit full_pre, busy_pre, wr_d, wr_s;
      int lvl;
      full_pre = q.size() == DEPTH;
      busy_pre = in_frame || q.size() > 0;
      lvl = q.size() > 15 ? 15 : q.size();
      exp_rdata = mem_addr == BASE + 4 ? {24'b0, 4'(lvl), 1'b0, m_ovf, full_pre, busy_pre} : 32'b0;
      wr_d = mem_addr == BASE && mem_write[0];
      wr_s = mem_addr == BASE + 4 && mem_write[0] && mem_wdata[2];
      if (line.size() == 0 && q.size() > 0) begin
        f = frame_of(q.pop_front());
        for (int i = 0; i < FB; i++) repeat (CLK_DIV) line.push_back(f[i]);
      end
      in_frame = line.size() > 0;
      exp_tx = in_frame ? line.pop_front() : 1'b1;
      if (wr_d) begin
        if (full_pre) m_ovf = 1'b1;
        else q.push_back(mem_wdata[7:0]);
      end else if (wr_s) m_ovf = 1'b0;
    end

  // every-cycle comparison against the model
  always @(negedge clk)
    if (run) begin
      check("tx_model", {31'b0, tx}, {31'b0, exp_tx});
      check("rdata_model", mem_rdata, exp_rdata);
    end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] we);
    mem_addr = a;
    mem_wdata = d;
    mem_write = we;
    step(1);
    mem_write = 4'b0;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    run = 1'b0;
    reset = 1'b0;
    mem_addr = '0;
    mem_write = '0;
    mem_wdata = '0;
    lit55 = 10'b10_1010_1010;
    step(3);
    check("reset_tx", {31'b0, tx}, 32'd1);
    check("reset_rdata", mem_rdata, 32'd0);
    run = 1'b1;
    reset = 1'b1;
    wr(BASE, 32'h55, 4'b0001);
    @(negedge clk);
    check("latency_pre_start", {31'b0, tx}, 32'd1);
    for (int k = 0; k < 36; k++) begin
      @(negedge clk);
      check("frame55_bit", {31'b0, tx}, {31'b0, lit55[k / CLK_DIV]});
    end
    step(12);
    for (int i = 0; i < 10; i++) wr(BASE, 32'h41 + i, 4'b0001);
    mem_addr = BASE + 4;
    step(1);
    check("status_overflow", mem_rdata, 32'h87);
    wr(BASE + 4, 32'h4, 4'b0001);
    check("status_before_clear", mem_rdata, 32'h87);
    step(1);
    check("status_cleared", mem_rdata, 32'h83);
    step(9 * FB * CLK_DIV + 10);
    check("status_drained", mem_rdata, 32'h0);
    mem_addr = 32'h0;
    wr(BASE, 32'hF0, 4'b0001);
    step(17);
    check("mid_frame_bit3", {31'b0, tx}, 32'd0);
    reset = 1'b0;
    #1;
    check("reset_tx_immediate", {31'b0, tx}, 32'd1);
    step(3);
    reset = 1'b1;
    mem_addr = BASE + 4;
    step(1);
    check("status_after_reset", mem_rdata, 32'h0);
    step(50);
    check("no_residual_tx", {31'b0, tx}, 32'd1);
    wr(BASE, 32'h41, 4'b0010);
    mem_addr = BASE + 8;
    step(1);
    check("rdata_other_addr", mem_rdata, 32'h0);
    step(5);
    check("byte1_no_tx", {31'b0, tx}, 32'd1);
    mem_addr = BASE + 4;
    step(1);
    check("byte1_status", mem_rdata, 32'h0);
    step(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
